multi_timer: RTL and testbench

Parametrised multi-channel timer peripheral on the CPU's memory-mapped device bus, the successor to the single-channel timer. It provides NUM_CH independent down-counters, each with a preset, an 8-bit prescaler, one-shot or auto-reload mode and a sticky interrupt flag. The per-channel interrupts are masked and OR-ed into one IntReq line that feeds the CPU's interrupt controller.

---
 rtl/multi_timer_pkg.sv | 25 ++
 rtl/multi_timer_channel.sv | 144 ++++++++++++++
 rtl/multi_timer.sv | 53 +++++
 tb/tb_multi_timer.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/multi_timer_pkg.sv
// Shared definitions for the multi-channel timer: register map, CTRL layout,
// mode encodings and the per-channel FSM states.
package multi_timer_pkg;

    localparam logic [1:0] REG_CTRL   = 2'b00;
    localparam logic [1:0] REG_PRESET = 2'b01;
    localparam logic [1:0] REG_STATUS = 2'b10;
    localparam logic [1:0] REG_COUNT  = 2'b11;

    localparam int CTRL_EN       = 0;
    localparam int CTRL_MODE_LO  = 1;
    localparam int CTRL_IM       = 3;
    localparam int CTRL_PRESC_LO = 4;

    localparam logic [1:0] MODE_ONESHOT = 2'b00;
    localparam logic [1:0] MODE_AUTO    = 2'b01;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_CNT,
        ST_EXPIRE
    } state_e;

endpackage

// File: rtl/multi_timer_channel.sv
// One timer channel: CTRL/PRESET/COUNT/PEND registers, 8-bit prescaler and
// the IDLE/LOAD/CNT/EXPIRE sequencer, plus its own read-back word.
module timer_channel
    import multi_timer_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        we,
    input  logic [1:0]  reg_sel,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        irq
);

    logic             en_q, en_d;
    logic [1:0]       mode_q, mode_d;
    logic             im_q, im_d;
    logic [7:0]       presc_q, presc_d;
    logic [7:0]       pcnt_q, pcnt_d;
    logic [WIDTH-1:0] preset_q, preset_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic             pend_q, pend_d;
    state_e           state_q, state_d;

    logic             ctrl_we, preset_we, status_we;
    logic             tick;
    logic [WIDTH-1:0] wval;

    assign wval      = wdata[WIDTH-1:0];
    assign ctrl_we   = we && (reg_sel == REG_CTRL);
    assign preset_we = we && (reg_sel == REG_PRESET);
    assign status_we = we && (reg_sel == REG_STATUS);
    // >= rather than == so a PRESC lowered mid-count cannot skip a tick and wrap
    assign tick      = (state_q == ST_CNT) && (pcnt_q >= presc_q);

    always_comb begin
        en_d     = en_q;
        mode_d   = mode_q;
        im_d     = im_q;
        presc_d  = presc_q;
        pcnt_d   = pcnt_q;
        preset_d = preset_q;
        count_d  = count_q;
        pend_d   = pend_q;
        state_d  = state_q;

        if (ctrl_we) begin
            en_d    = wdata[CTRL_EN];
            mode_d  = wdata[CTRL_MODE_LO +: 2];
            im_d    = wdata[CTRL_IM];
            presc_d = wdata[CTRL_PRESC_LO +: 8];
        end
        if (preset_we) begin
            preset_d = wval;
        end
        if (status_we && wdata[0]) begin
            pend_d = 1'b0;
        end

        // Expiry below is evaluated after the W1C so a same-cycle set wins
        case (state_q)
            ST_IDLE: begin
                if (preset_we && (wval != '0)) begin
                    pcnt_d  = '0;
                    state_d = ST_LOAD;
                end else if (en_q && (count_q != '0)) begin
                    state_d = ST_CNT;
                end
            end
            ST_LOAD: begin
                count_d = preset_q;
                state_d = en_q ? ST_CNT : ST_IDLE;
            end
            ST_CNT: begin
                if (!en_q) begin
                    state_d = ST_IDLE;
                end else if (tick) begin
                    pcnt_d = '0;
                    if (count_q == WIDTH'(1)) begin
                        count_d = '0;
                        pend_d  = 1'b1;
                        state_d = ST_EXPIRE;
                    end else begin
                        count_d = count_q - WIDTH'(1);
                    end
                end else begin
                    pcnt_d = pcnt_q + 8'd1;
                end
            end
            ST_EXPIRE: begin
                if (en_q && (mode_q == MODE_AUTO)) begin
                    count_d = preset_q;
                    state_d = ST_CNT;
                end else begin
                    if (mode_q != MODE_AUTO) begin
                        en_d = 1'b0;
                    end
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            en_q     <= 1'b0;
            mode_q   <= MODE_ONESHOT;
            im_q     <= 1'b0;
            presc_q  <= '0;
            pcnt_q   <= '0;
            preset_q <= '0;
            count_q  <= '0;
            pend_q   <= 1'b0;
            state_q  <= ST_IDLE;
        end else begin
            en_q     <= en_d;
            mode_q   <= mode_d;
            im_q     <= im_d;
            presc_q  <= presc_d;
            pcnt_q   <= pcnt_d;
            preset_q <= preset_d;
            count_q  <= count_d;
            pend_q   <= pend_d;
            state_q  <= state_d;
        end
    end

    always_comb begin
        rdata = '0;
        case (reg_sel)
            REG_CTRL:   rdata = {20'b0, presc_q, im_q, mode_q, en_q};
            REG_PRESET: rdata = 32'(preset_q);
            REG_STATUS: rdata = {31'b0, pend_q};
            REG_COUNT:  rdata = 32'(count_q);
            default:    rdata = '0;
        endcase
    end

    assign irq = pend_q & im_q;

endmodule

// File: rtl/multi_timer.sv
// Multi-channel timer top: per-channel write decode, read mux and the
// masked interrupt OR feeding the CPU interrupt controller.
module multi_timer
    import multi_timer_pkg::*;
#(
    parameter int NUM_CH = 2,
    parameter int WIDTH  = 32,
    parameter int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [CH_W+3:2]  addr,
    input  logic             we,
    input  logic [31:0]      Din,
    output logic [31:0]      Dout,
    output logic             IntReq
);

    logic [CH_W-1:0]   ch_sel;
    logic [1:0]        reg_sel;
    logic [31:0]       rd_data [NUM_CH];
    logic [NUM_CH-1:0] irq;

    assign ch_sel  = addr[CH_W+3:4];
    assign reg_sel = addr[3:2];

    // Indices past NUM_CH match no instance, so their writes fall away
    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        timer_channel #(
            .WIDTH(WIDTH)
        ) u_ch (
            .clk     (clk),
            .reset_n (reset_n),
            .we      (we && (ch_sel == CH_W'(g))),
            .reg_sel (reg_sel),
            .wdata   (Din),
            .rdata   (rd_data[g]),
            .irq     (irq[g])
        );
    end

    always_comb begin
        Dout = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (ch_sel == CH_W'(i)) begin
                Dout = rd_data[i];
            end
        end
    end

    assign IntReq = |irq;

endmodule

// File: tb/tb_multi_timer.sv
// Directed bench for multi_timer (3 channels): expected register/IntReq values
// are queued as stimulus is driven and checked in order as the cycles pass.
module tb_multi_timer;
    import multi_timer_pkg::*;

    localparam int NUM_CH = 3;
    localparam int WIDTH  = 32;
    localparam int CH_W   = 2;

    logic             clk;
    logic             reset_n;
    logic             we;
    logic [CH_W+3:2]  addr;
    logic [31:0]      din;
    logic [31:0]      dout;
    logic             int_req;

    int vectors     = 0;
    int miscompares = 0;

    typedef struct {
        string           tag;
        bit              is_irq;
        logic [CH_W+1:0] a;
        logic [31:0]     value;
    } exp_t;

    exp_t sb[$];

    multi_timer #(
        .NUM_CH (NUM_CH),
        .WIDTH  (WIDTH),
        .CH_W   (CH_W)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .addr    (addr),
        .we      (we),
        .Din     (din),
        .Dout    (dout),
        .IntReq  (int_req)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    function automatic logic [CH_W+1:0] reg_addr(input int ch, input logic [1:0] r);
        logic [CH_W-1:0] c;
        c = CH_W'(ch);
        return {c, r};
    endfunction

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Drives one bus write; returns at the falling edge after the sampling edge
    task automatic applyStimulus(input int ch, input logic [1:0] r, input logic [31:0] data);
        addr = reg_addr(ch, r);
        din  = data;
        we   = 1'b1;
        @(negedge clk);
        we   = 1'b0;
        din  = '0;
    endtask

    task automatic expectReg(input string tag, input int ch, input logic [1:0] r,
                             input logic [31:0] v);
        exp_t e;
        e.tag    = tag;
        e.is_irq = 1'b0;
        e.a      = reg_addr(ch, r);
        e.value  = v;
        sb.push_back(e);
    endtask

    task automatic expectIrq(input string tag, input logic v);
        exp_t e;
        e.tag    = tag;
        e.is_irq = 1'b1;
        e.a      = '0;
        e.value  = {31'b0, v};
        sb.push_back(e);
    endtask

    task automatic checkOutput();
        exp_t        e;
        logic [31:0] obs;
        vectors++;
        assert (sb.size() != 0) else begin
            miscompares++;
            $error("[TB] FAIL scoreboard_empty: observed 0 entries, required at least 1");
            return;
        end
        e = sb.pop_front();
        if (e.is_irq) begin
            #1;
            obs = {31'b0, int_req};
        end else begin
            addr = e.a;
            #1;
            obs = dout;
        end
        assert (obs === e.value) else begin
            miscompares++;
            $error("[TB] FAIL %s: observed 0x%08h, required 0x%08h", e.tag, obs, e.value);
        end
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        reset_n = 1'b0;
        we      = 1'b0;
        addr    = '0;
        din     = '0;
        step(3);
        reset_n = 1'b1;
        step(1);

        $display("[TB] reset state");
        for (int c = 0; c < NUM_CH; c++) begin
            for (int r = 0; r < 4; r++) begin
                expectReg($sformatf("reset_ch%0d_r%0d", c, r), c, 2'(r), 32'h0);
                checkOutput();
            end
            step(1);
        end
        expectIrq("reset_irq", 1'b0);
        checkOutput();

        $display("[TB] one-shot ch0");
        applyStimulus(0, REG_CTRL, 32'h009);
        applyStimulus(0, REG_PRESET, 32'd5);
        for (int k = 1; k <= 6; k++) begin
            expectReg($sformatf("os_count_k%0d", k), 0, REG_COUNT, 32'(6 - k));
            expectIrq($sformatf("os_irq_k%0d", k), k == 6);
        end
        for (int k = 1; k <= 6; k++) begin
            step(1);
            checkOutput();
            checkOutput();
        end
        step(2);
        expectReg("os_ctrl_en_cleared", 0, REG_CTRL, 32'h008);
        expectReg("os_count_stays0", 0, REG_COUNT, 32'h0);
        expectIrq("os_irq_held", 1'b1);
        checkOutput(); checkOutput(); checkOutput();
        applyStimulus(0, REG_STATUS, 32'h1);
        expectIrq("os_irq_after_w1c", 1'b0);
        expectReg("os_status_after_w1c", 0, REG_STATUS, 32'h0);
        checkOutput(); checkOutput();

        $display("[TB] auto-reload ch1 with prescaler");
        applyStimulus(1, REG_CTRL, 32'h01B);
        applyStimulus(1, REG_PRESET, 32'd3);
        for (int cyc = 1; cyc <= 8; cyc++) begin
            step(1);
            expectIrq($sformatf("ar_irq_c%0d", cyc), cyc >= 7);
            checkOutput();
        end
        expectReg("ar_count_reloaded", 1, REG_COUNT, 32'd3);
        checkOutput();
        applyStimulus(1, REG_STATUS, 32'h1);
        expectIrq("ar_irq_w1c", 1'b0);
        checkOutput();
        for (int cyc = 10; cyc <= 14; cyc++) begin
            step(1);
            expectIrq($sformatf("ar_irq_c%0d", cyc), cyc >= 14);
            checkOutput();
        end
        applyStimulus(1, REG_CTRL, 32'h0);
        applyStimulus(1, REG_STATUS, 32'h1);
        expectIrq("ar_irq_stopped", 1'b0);
        checkOutput();

        $display("[TB] mask and one-shot EN clear on ch2");
        applyStimulus(2, REG_CTRL, 32'h001);
        applyStimulus(2, REG_PRESET, 32'd2);
        step(3);
        expectReg("mask_pend_set", 2, REG_STATUS, 32'h1);
        expectIrq("mask_irq_low", 1'b0);
        checkOutput(); checkOutput();
        applyStimulus(2, REG_CTRL, 32'h009);
        expectIrq("mask_irq_after_im", 1'b1);
        expectReg("expire_en_clear_wins", 2, REG_CTRL, 32'h008);
        checkOutput(); checkOutput();
        applyStimulus(2, REG_STATUS, 32'h1);
        expectIrq("mask_irq_cleared", 1'b0);
        checkOutput();

        $display("[TB] pause and resume on ch2");
        applyStimulus(2, REG_CTRL, 32'h001);
        applyStimulus(2, REG_PRESET, 32'd6);
        step(2);
        applyStimulus(2, REG_CTRL, 32'h000);
        expectReg("pause_count4", 2, REG_COUNT, 32'd4);
        checkOutput();
        step(3);
        expectReg("pause_count_held", 2, REG_COUNT, 32'd4);
        checkOutput();
        applyStimulus(2, REG_CTRL, 32'h001);
        step(2);
        expectReg("resume_count3", 2, REG_COUNT, 32'd3);
        checkOutput();
        step(3);
        expectReg("resume_expired", 2, REG_STATUS, 32'h1);
        checkOutput();
        applyStimulus(2, REG_STATUS, 32'h1);

        $display("[TB] collisions on ch0");
        applyStimulus(0, REG_CTRL, 32'h009);
        applyStimulus(0, REG_PRESET, 32'd3);
        step(3);
        applyStimulus(0, REG_STATUS, 32'h1);
        expectReg("w1c_on_expiry_set_wins", 0, REG_STATUS, 32'h1);
        expectIrq("w1c_on_expiry_irq", 1'b1);
        checkOutput(); checkOutput();
        applyStimulus(0, REG_STATUS, 32'h1);
        applyStimulus(0, REG_CTRL, 32'h009);
        applyStimulus(0, REG_PRESET, 32'h0);
        step(4);
        expectReg("preset0_count", 0, REG_COUNT, 32'h0);
        expectReg("preset0_status", 0, REG_STATUS, 32'h0);
        expectIrq("preset0_irq", 1'b0);
        checkOutput(); checkOutput(); checkOutput();

        $display("[TB] asynchronous reset mid-count");
        applyStimulus(0, REG_PRESET, 32'd5);
        step(2);
        expectReg("pre_reset_count4", 0, REG_COUNT, 32'd4);
        checkOutput();
        reset_n = 1'b0;
        expectReg("async_reset_count", 0, REG_COUNT, 32'h0);
        checkOutput();
        step(2);
        reset_n = 1'b1;
        for (int cyc = 1; cyc <= 8; cyc++) begin
            step(1);
            expectIrq($sformatf("post_reset_irq_c%0d", cyc), 1'b0);
            checkOutput();
        end
        expectReg("post_reset_ctrl0", 0, REG_CTRL, 32'h0);
        expectReg("post_reset_count1", 1, REG_COUNT, 32'h0);
        expectReg("post_reset_status0", 0, REG_STATUS, 32'h0);
        checkOutput(); checkOutput(); checkOutput();

        $display("[TB] channel isolation");
        for (int c = 0; c < NUM_CH; c++) begin
            applyStimulus(c, REG_CTRL, 32'h009);
        end
        applyStimulus(0, REG_PRESET, 32'd2);
        applyStimulus(1, REG_PRESET, 32'd4);
        applyStimulus(2, REG_PRESET, 32'd6);
        for (int cyc = 2; cyc <= 10; cyc++) begin
            if (cyc > 2) step(1);
            expectReg($sformatf("iso_ch0_c%0d", cyc), 0, REG_STATUS, {31'b0, cyc >= 3});
            expectReg($sformatf("iso_ch1_c%0d", cyc), 1, REG_STATUS, {31'b0, cyc >= 6});
            expectReg($sformatf("iso_ch2_c%0d", cyc), 2, REG_STATUS, {31'b0, cyc >= 9});
            expectIrq($sformatf("iso_irq_c%0d", cyc), cyc >= 3);
            checkOutput(); checkOutput(); checkOutput(); checkOutput();
        end

        applyStimulus(3, REG_CTRL, 32'h009);
        applyStimulus(3, REG_PRESET, 32'd7);
        expectReg("ch3_ctrl_reads0", 3, REG_CTRL, 32'h0);
        expectReg("ch3_preset_reads0", 3, REG_PRESET, 32'h0);
        expectReg("ch3_count_reads0", 3, REG_COUNT, 32'h0);
        expectReg("ch0_preset_intact", 0, REG_PRESET, 32'd2);
        checkOutput(); checkOutput(); checkOutput(); checkOutput();
        step(1);
        expectReg("ch1_preset_intact", 1, REG_PRESET, 32'd4);
        expectReg("ch2_preset_intact", 2, REG_PRESET, 32'd6);
        checkOutput(); checkOutput();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
